minisys_mem_stage: RTL and testbench
====================================

Name: minisys_mem_stage

Overview:
- Pipeline MEM stage; sits directly downstream of the EXE stage and consumes its EXE/MEM register outputs.
- Performs data-memory load/store over a req/ack data-memory port with variable wait states.
- Generates byte lanes, extracts and extends load data, and detects misaligned accesses and bus timeouts.
- Holds the MEM/WB pipeline register and raises a stall while an access is outstanding.

Parameters:
- TIMEOUT, 16, max WAIT cycles before an access is aborted with a bus error (range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- regwriteM  in  1  register write enable from EXE/MEM.
- mem2regM  in  1  result comes from memory (load).
- memwriteM  in  4  store size code: 0000 none, 0001 byte, 0011 half, 1111 word.
- op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM  in  1 each  load type (at most one high).
- write31M  in  1  link write to $31.
- alu_outM  in  32  effective address / ALU result.
- write_dataM  in  32  store data (right-aligned).
- write_regM  in  5  destination register.
- pcplus4M  in  32  PC+4 of instruction.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_be  out  4  byte enables, bit i = byte at addr+i (little-endian).
- dmem_addr  out  32  word-aligned address ({alu_outM[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete (may be same cycle as req).
- stall_mem  out  1  hold IF..MEM stages this cycle.
- regwriteW, mem2regW, write31W  out  1 each  registered controls.
- write_regW  out  5  registered destination.
- alu_outW, read_dataW, pcplus4W  out  32 each  registered data.
- mem_excW  out  2  00 none, 01 misaligned, 10 bus timeout.

Behaviour:
- Reset (synchronous, rst=1): FSM to IDLE, timeout counter 0, all W outputs 0, dmem_req 0, stall_mem 0.
- Memory op: memop = mem2regM | (memwriteM != 0). Size is taken from the op_* flags for loads and from memwriteM for stores.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No request is issued. MEM/WB loads the instruction with regwriteW=0 and mem_excW=01. No stall.
- Byte lanes: dmem_be = size mask << addr[1:0]. wdata is byte {4{b}}, half {2{h}}, word as-is. dmem_be = 1111 for loads.
- FSM states: IDLE, WAIT.
  - IDLE: aligned memop drives dmem_req=1 combinationally.
    - ack=1 in the same cycle: zero-wait; MEM/WB captures at this edge; stay IDLE.
    - ack=0: stall_mem=1, go to WAIT, counter cleared.
  - WAIT: dmem_req=1 and stall_mem=1. Upstream holds M inputs stable. Counter increments each cycle.
    - ack=1: stall_mem=0 that cycle; MEM/WB captures rdata; go to IDLE.
    - Counter==TIMEOUT-1 with no ack: req drops next cycle; MEM/WB loads the instruction with regwriteW=0 and mem_excW=10; stall_mem=0 that cycle; go to IDLE. A late ack arriving in IDLE with no req is ignored.
- stall_mem = dmem_req & ~dmem_ack & ~timeout_hit (combinational).
- MEM/WB register:
  - Loads M values when stall_mem=0.
  - When stall_mem=1 it loads a bubble (regwriteW=0, mem2regW=0, write31W=0, mem_excW=00); other W fields are don't-care.
- Load extraction: select byte/half by addr[1:0] from rdata. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through. Result goes to read_dataW. read_dataW = 0 for non-loads.
- Stores write nothing to registers (regwriteW follows regwriteM, which is 0 for stores).
- Reset asserted in WAIT: abort immediately; dmem_req=0 in the following cycle; no W update other than reset values.
- Latency: one clock from M to W for zero-wait and non-memory ops; 1+N clocks for N wait states.

Test Plan:
- ALU op, alu_outM=0x12345678, regwriteM=1, write_regM=5 -> next cycle alu_outW=0x12345678, regwriteW=1, write_regW=5, no req, stall_mem=0.
- lb from addr 0x103, ack same cycle, rdata=0x80FF7F01 -> dmem_be=1111, read_dataW=0xFFFFFF80. Repeat with lbu -> 0x00000080.
- sh of write_dataM=0x0000BEEF at addr 0x202, ack after 3 cycles -> dmem_be=1100, wdata=0xBEEFBEEF, stall_mem high exactly 3 cycles, one bubble in W per stalled cycle, dmem_addr=0x200.
- lw at addr 0x101 -> no dmem_req, regwriteW=0, mem_excW=01, no stall.
- lw with ack never asserted, TIMEOUT=4 -> stall_mem high for 4 cycles, then mem_excW=10, regwriteW=0, req low, FSM IDLE; a subsequent ALU op proceeds normally.
- rst=1 asserted during WAIT of an lhu -> next cycle dmem_req=0, stall_mem=0, all W outputs 0.

Source files
------------

// File: rtl/minisys_mem_stage.sv
// MEM pipeline stage: req/ack data-memory port with wait states, byte-lane steering,
// load extension, misalign/timeout detection and the MEM/WB register.
module minisys_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteM,
  input  logic        mem2regM,
  input  logic [3:0]  memwriteM,
  input  logic        op_lbM,
  input  logic        op_lbuM,
  input  logic        op_lhM,
  input  logic        op_lhuM,
  input  logic        op_lwM,
  input  logic        write31M,
  input  logic [31:0] alu_outM,
  input  logic [31:0] write_dataM,
  input  logic [4:0]  write_regM,
  input  logic [31:0] pcplus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        regwriteW,
  output logic        mem2regW,
  output logic        write31W,
  output logic [4:0]  write_regW,
  output logic [31:0] alu_outW,
  output logic [31:0] read_dataW,
  output logic [31:0] pcplus4W,
  output logic [1:0]  mem_excW
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int CNT_W     = 8;

  typedef enum logic {IDLE, WAIT} stateT;

  typedef struct packed {
    logic        regwrite;
    logic        mem2reg;
    logic        write31;
    logic [4:0]  writeReg;
    logic [31:0] aluOut;
    logic [31:0] readData;
    logic [31:0] pcplus4;
    logic [1:0]  exc;
  } memWbT;

  stateT             state, stateNxt;
  logic [CNT_W-1:0]  cnt;
  logic              timeoutHit;
  memWbT             wb, wbNxt;

  logic              isLoad, isStore, memOp, isHalf, isWord, misaligned, accessOk;
  logic [3:0]        sizeMask;
  logic [1:0]        byteOff;

  logic [NUM_LANES-1:0][LANE_W-1:0] wdIn, wdLanes, rdLanes;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       loadData;

  // Size comes from the load-type flags for loads and from the store code for stores.
  assign byteOff    = alu_outM[1:0];
  assign isLoad     = mem2regM;
  assign isStore    = |memwriteM;
  assign memOp      = isLoad | isStore;
  assign isHalf     = isLoad ? (op_lhM | op_lhuM) : (memwriteM == 4'b0011);
  assign isWord     = isLoad ? op_lwM : (memwriteM == 4'b1111);
  assign sizeMask   = isWord ? 4'b1111 : (isHalf ? 4'b0011 : 4'b0001);
  assign misaligned = memOp & ((isHalf & byteOff[0]) | (isWord & (|byteOff)));
  assign accessOk   = memOp & ~misaligned;

  assign wdIn = write_dataM;
  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    assign wdLanes[i] = isWord ? wdIn[i] : (isHalf ? wdIn[i % 2] : wdIn[0]);
  end

  assign dmem_addr  = {alu_outM[31:2], 2'b00};
  assign dmem_wdata = wdLanes;
  assign dmem_be    = isLoad ? 4'b1111 : (sizeMask << byteOff);
  assign dmem_we    = dmem_req & isStore;

  assign rdLanes = dmem_rdata;
  assign byteSel = rdLanes[byteOff];
  assign halfSel = byteOff[1] ? {rdLanes[3], rdLanes[2]} : {rdLanes[1], rdLanes[0]};

  always_comb begin
    loadData = dmem_rdata;
    if (op_lbM)       loadData = {{24{byteSel[7]}}, byteSel};
    else if (op_lbuM) loadData = {24'b0, byteSel};
    else if (op_lhM)  loadData = {{16{halfSel[15]}}, halfSel};
    else if (op_lhuM) loadData = {16'b0, halfSel};
  end

  // Reset dominates the request so an in-flight access is dropped at once.
  always_comb begin
    stateNxt   = state;
    dmem_req   = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = accessOk;
        if (accessOk && !dmem_ack) stateNxt = WAIT;
      end
      WAIT: begin
        dmem_req   = 1'b1;
        timeoutHit = !dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));
        if (dmem_ack || timeoutHit) stateNxt = IDLE;
      end
    endcase
    if (rst) dmem_req = 1'b0;
  end

  assign stall_mem = dmem_req & ~dmem_ack & ~timeoutHit;

  always_comb begin
    wbNxt.regwrite = regwriteM & ~misaligned & ~timeoutHit;
    wbNxt.mem2reg  = mem2regM;
    wbNxt.write31  = write31M;
    wbNxt.writeReg = write_regM;
    wbNxt.aluOut   = alu_outM;
    wbNxt.pcplus4  = pcplus4M;
    wbNxt.readData = (isLoad & accessOk & dmem_ack) ? loadData : 32'b0;
    wbNxt.exc      = misaligned ? 2'b01 : (timeoutHit ? 2'b10 : 2'b00);
    if (stall_mem) begin
      wbNxt.regwrite = 1'b0;
      wbNxt.mem2reg  = 1'b0;
      wbNxt.write31  = 1'b0;
      wbNxt.exc      = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      wb    <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= (state == IDLE) ? '0 : cnt + CNT_W'(1);
      wb    <= wbNxt;
    end
  end

  assign regwriteW  = wb.regwrite;
  assign mem2regW   = wb.mem2reg;
  assign write31W   = wb.write31;
  assign write_regW = wb.writeReg;
  assign alu_outW   = wb.aluOut;
  assign read_dataW = wb.readData;
  assign pcplus4W   = wb.pcplus4;
  assign mem_excW   = wb.exc;
endmodule

// File: tb/tb_minisys_mem_stage.sv
// Directed bench for minisys_mem_stage (TIMEOUT=4): ALU pass-through, load extension,
// byte lanes, wait states, misalign, bus timeout and reset during WAIT.
module tb_minisys_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        regwriteM, mem2regM, op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM, write31M;
  logic [3:0]  memwriteM;
  logic [31:0] alu_outM, write_dataM, pcplus4M;
  logic [4:0]  write_regM;
  logic        dmem_req, dmem_we, dmem_ack, stall_mem;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        regwriteW, mem2regW, write31W;
  logic [4:0]  write_regW;
  logic [31:0] alu_outW, read_dataW, pcplus4W;
  logic [1:0]  mem_excW;

  int checks = 0;
  int failures = 0;

  minisys_mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .regwriteM(regwriteM), .mem2regM(mem2regM), .memwriteM(memwriteM),
    .op_lbM(op_lbM), .op_lbuM(op_lbuM), .op_lhM(op_lhM), .op_lhuM(op_lhuM), .op_lwM(op_lwM),
    .write31M(write31M), .alu_outM(alu_outM), .write_dataM(write_dataM),
    .write_regM(write_regM), .pcplus4M(pcplus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_mem(stall_mem),
    .regwriteW(regwriteW), .mem2regW(mem2regW), .write31W(write31W),
    .write_regW(write_regW), .alu_outW(alu_outW), .read_dataW(read_dataW),
    .pcplus4W(pcplus4W), .mem_excW(mem_excW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    regwriteM = 0; mem2regM = 0; memwriteM = 4'b0000;
    op_lbM = 0; op_lbuM = 0; op_lhM = 0; op_lhuM = 0; op_lwM = 0; write31M = 0;
    alu_outM = '0; write_dataM = '0; write_regM = '0; pcplus4M = '0;
    dmem_rdata = '0; dmem_ack = 0;
  endtask

  initial begin
    rst = 1;
    nop();
    tick();
    tick();
    // reset state
    chk("rst_req",     32'(dmem_req),   32'd0);
    chk("rst_stall",   32'(stall_mem),  32'd0);
    chk("rst_regwr",   32'(regwriteW),  32'd0);
    chk("rst_alu",     alu_outW,        32'd0);
    chk("rst_rdata",   read_dataW,      32'd0);
    chk("rst_exc",     32'(mem_excW),   32'd0);
    rst = 0;
    tick();

    // ALU op
    regwriteM = 1; alu_outM = 32'h12345678; write_regM = 5'd5; pcplus4M = 32'h0000_0404;
    #1;
    chk("alu_req",   32'(dmem_req),  32'd0);
    chk("alu_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("alu_aluW",  alu_outW,         32'h12345678);
    chk("alu_regwr", 32'(regwriteW),   32'd1);
    chk("alu_wreg",  32'(write_regW),  32'd5);
    chk("alu_pc4",   pcplus4W,         32'h0000_0404);
    chk("alu_rdata", read_dataW,       32'd0);

    // lb 0x103, zero-wait
    nop();
    regwriteM = 1; mem2regM = 1; op_lbM = 1; alu_outM = 32'h103; write_regM = 5'd7;
    dmem_rdata = 32'h80FF7F01; dmem_ack = 1;
    #1;
    chk("lb_req",   32'(dmem_req),  32'd1);
    chk("lb_we",    32'(dmem_we),   32'd0);
    chk("lb_be",    32'(dmem_be),   32'hF);
    chk("lb_addr",  dmem_addr,      32'h100);
    chk("lb_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("lb_data",  read_dataW,     32'hFFFFFF80);
    chk("lb_regwr", 32'(regwriteW), 32'd1);
    chk("lb_m2r",   32'(mem2regW),  32'd1);

    op_lbM = 0; op_lbuM = 1;
    tick();
    chk("lbu_data", read_dataW, 32'h00000080);

    op_lbuM = 0; op_lhM = 1; alu_outM = 32'h102;
    tick();
    chk("lh_data", read_dataW, 32'hFFFF80FF);

    op_lhM = 0; op_lhuM = 1; alu_outM = 32'h100;
    tick();
    chk("lhu_data", read_dataW, 32'h00007F01);

    op_lhuM = 0; op_lwM = 1; alu_outM = 32'h104;
    tick();
    chk("lw_data", read_dataW, 32'h80FF7F01);

    // sb 0x101, zero-wait
    nop();
    memwriteM = 4'b0001; alu_outM = 32'h101; write_dataM = 32'h123456A5; dmem_ack = 1;
    #1;
    chk("sb_be",    32'(dmem_be),  32'b0010);
    chk("sb_wdata", dmem_wdata,    32'hA5A5A5A5);
    chk("sb_we",    32'(dmem_we),  32'd1);
    tick();

    // sh 0x202, ack after 3 cycles
    nop();
    memwriteM = 4'b0011; alu_outM = 32'h202; write_dataM = 32'h0000BEEF;
    #1;
    chk("sh_be",    32'(dmem_be),  32'b1100);
    chk("sh_wdata", dmem_wdata,    32'hBEEFBEEF);
    chk("sh_addr",  dmem_addr,     32'h200);
    chk("sh_we",    32'(dmem_we),  32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("sh_stall", 32'(stall_mem), 32'd1);
      chk("sh_req",   32'(dmem_req),  32'd1);
      tick();
      chk("sh_bubble_exc", 32'(mem_excW), 32'd0);
      chk("sh_bubble_m2r", 32'(mem2regW), 32'd0);
    end
    dmem_ack = 1;
    #1;
    chk("sh_ack_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("sh_done_alu",   alu_outW,        32'h202);
    chk("sh_done_regwr", 32'(regwriteW),  32'd0);
    chk("sh_done_exc",   32'(mem_excW),   32'd0);

    // misaligned lw
    nop();
    regwriteM = 1; mem2regM = 1; op_lwM = 1; alu_outM = 32'h101; write_regM = 5'd9;
    #1;
    chk("mis_req",   32'(dmem_req),  32'd0);
    chk("mis_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("mis_regwr", 32'(regwriteW), 32'd0);
    chk("mis_exc",   32'(mem_excW),  32'b01);

    // lw timeout (TIMEOUT=4)
    alu_outM = 32'h300; write_regM = 5'd10;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", 32'(stall_mem), 32'd1);
      tick();
      chk("to_bubble_regwr", 32'(regwriteW), 32'd0);
      chk("to_bubble_m2r",   32'(mem2regW),  32'd0);
      chk("to_bubble_exc",   32'(mem_excW),  32'd0);
    end
    chk("to_last_stall", 32'(stall_mem), 32'd0);
    chk("to_last_req",   32'(dmem_req),  32'd1);
    tick();
    chk("to_exc",   32'(mem_excW),  32'b10);
    chk("to_regwr", 32'(regwriteW), 32'd0);
    chk("to_alu",   alu_outW,       32'h300);

    // following ALU op with a stray late ack
    nop();
    regwriteM = 1; alu_outM = 32'hCAFE0001; write_regM = 5'd3; dmem_ack = 1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("post_req",   32'(dmem_req),  32'd0);
    chk("post_stall", 32'(stall_mem), 32'd0);
    tick();
    chk("post_alu",   alu_outW,       32'hCAFE0001);
    chk("post_regwr", 32'(regwriteW), 32'd1);
    chk("post_exc",   32'(mem_excW),  32'd0);
    chk("post_rdata", read_dataW,     32'd0);

    // reset during WAIT of lhu
    nop();
    regwriteM = 1; mem2regM = 1; op_lhuM = 1; alu_outM = 32'h402; write_regM = 5'd4;
    pcplus4M = 32'h808;
    #1;
    chk("rw_stall0", 32'(stall_mem), 32'd1);
    tick();
    chk("rw_stall1", 32'(stall_mem), 32'd1);
    rst = 1;
    tick();
    nop();
    #1;
    chk("rw_req",   32'(dmem_req),   32'd0);
    chk("rw_stall", 32'(stall_mem),  32'd0);
    chk("rw_regwr", 32'(regwriteW),  32'd0);
    chk("rw_m2r",   32'(mem2regW),   32'd0);
    chk("rw_wreg",  32'(write_regW), 32'd0);
    chk("rw_alu",   alu_outW,        32'd0);
    chk("rw_pc4",   pcplus4W,        32'd0);
    chk("rw_exc",   32'(mem_excW),   32'd0);
    rst = 0;
    tick();
    chk("rw_idle_req",   32'(dmem_req),  32'd0);
    chk("rw_idle_stall", 32'(stall_mem), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
